safe_lock: RTL and testbench
============================

Name: safe_lock

Overview:
- Parametrised keypad-lock controller: next generation of the fixed 4-digit PIN safe.
- Accepts a stream of DIGIT_W-bit digits and compares a full PIN_LEN-digit entry against a stored, reprogrammable PIN.
- Counts failed attempts and enforces a timed lockout after MAX_TRIES failures; supports relock and PIN change while unlocked.
- Sits behind the keypad/debounce front end and drives the latch-release logic.

Parameters:
- DIGIT_W, 4, width of one digit.
- PIN_LEN, 4, digits per PIN (≥1).
- MAX_TRIES, 3, consecutive failed entries before lockout (≥1).
- LOCKOUT_CYCLES, 16, cycles locked_out stays high (≥1).
- RESET_PIN, 16'hC0DE, PIN loaded at reset; DIGIT_W*PIN_LEN bits, first digit in the MSBs.
- TIMEOUT_CYCLES, 32, inter-digit timeout; used only with SAFE_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- din  in  DIGIT_W  entered digit
- din_valid  in  1  din is sampled this cycle
- relock  in  1  return from UNLOCKED to ENTRY
- prog_valid  in  1  load prog_pin as the new PIN (honoured only when unlocked)
- prog_pin  in  DIGIT_W*PIN_LEN  new PIN, first digit in the MSBs
- unlocked  out  1  state == UNLOCKED
- locked_out  out  1  state == LOCKOUT
- fail_count  out  $clog2(MAX_TRIES+1)  consecutive failed entries
- digits_entered  out  $clog2(PIN_LEN+1)  digits accepted in the current entry

Behaviour:
- All outputs are registered and change on the clk edge after the causing input is sampled.
- Reset values: state ENTRY; stored PIN = RESET_PIN; unlocked 0; locked_out 0; fail_count 0; digits_entered 0; mismatch flag 0; lockout timer 0.
- Reset has priority over every other input, including mid-entry and during lockout.
- States are ENTRY, UNLOCKED and LOCKOUT.
- ENTRY, each din_valid:
  - din is compared with stored digit[digits_entered]; digit 0 is the MSBs.
  - A miscompare sets the sticky mismatch flag. There is no early abort: position of the wrong digit is not revealed.
  - digits_entered increments on each digit that is not the last.
- ENTRY, final digit (digits_entered == PIN_LEN-1):
  - Match with mismatch flag clear → UNLOCKED; fail_count ← 0.
  - Otherwise, if fail_count+1 == MAX_TRIES → LOCKOUT; timer ← LOCKOUT_CYCLES; fail_count holds MAX_TRIES.
  - Otherwise fail_count increments and state stays ENTRY.
  - In every case digits_entered ← 0 and mismatch ← 0.
- UNLOCKED:
  - din_valid is ignored.
  - prog_valid loads the stored PIN from prog_pin; state stays UNLOCKED.
  - relock → ENTRY on the next edge.
  - prog_valid and relock in the same cycle: the PIN is written and the block relocks.
  - prog_valid in any state other than UNLOCKED is ignored.
- LOCKOUT:
  - din_valid and relock are ignored.
  - The timer decrements each cycle; locked_out is high for exactly LOCKOUT_CYCLES cycles.
  - When the timer reaches 0 → ENTRY; fail_count ← 0.
- PIN_LEN=1: every din_valid in ENTRY is a complete entry.

Optional Feature:
- Macro SAFE_TIMEOUT_EN.
- When defined: in ENTRY with digits_entered > 0, TIMEOUT_CYCLES consecutive cycles without din_valid abandon the partial entry.
  - digits_entered ← 0 and mismatch ← 0.
  - fail_count is unchanged; an abandoned entry is not a failure.
  - The idle counter restarts on every din_valid.
  - A din_valid on the cycle the count expires is treated as digit 0 of a new entry.
- When not defined: a partial entry persists indefinitely, and the TIMEOUT_CYCLES parameter is unused.

Test Plan:
- Correct PIN: after reset, digits C,0,D,E with din_valid on consecutive cycles → unlocked=1 on the edge after E; fail_count=0.
- Wrong digit: enter C,1,D,E → unlocked stays 0; digits_entered counts 1,2,3 then 0; fail_count=1 only after the 4th digit, with no early abort.
- Lockout: three wrong entries → locked_out=1 for exactly 16 cycles, and a correct PIN during lockout is ignored; after lockout fail_count=0, and C,0,D,E then unlocks.
- Reprogramming: unlock, then prog_valid with prog_pin=16'h1234 and relock in the same cycle → unlocked=0; C,0,D,E now fails; 1,2,3,4 unlocks.
- Reset mid-operation: assert reset after 2 digits, and again during lockout → all outputs return to their reset values next edge; the stored PIN reverts to C0DE.
- With SAFE_TIMEOUT_EN: enter C,0, idle 32 cycles → digits_entered=0 and fail_count=0; a subsequent C,0,D,E unlocks.

Source files
------------

// File: rtl/safe_lock.sv
// safe_lock: keypad lock controller with reprogrammable PIN and timed lockout.
// Digits stream in on din/din_valid and the whole entry is judged on its last
// digit. A wrong digit never aborts early, so the entry gives no hint of where
// it went wrong.
// Optional feature: define SAFE_TIMEOUT_EN to abandon a partial entry after
// TIMEOUT_CYCLES idle cycles. Without it, a partial entry is kept indefinitely.
module safe_lock #(
    parameter int                            DIGIT_W        = 4,
    parameter int                            PIN_LEN        = 4,
    parameter int                            MAX_TRIES      = 3,
    parameter int                            LOCKOUT_CYCLES = 16,
    parameter logic [DIGIT_W*PIN_LEN-1:0]    RESET_PIN      = 16'hC0DE,
    parameter int                            TIMEOUT_CYCLES = 32
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [DIGIT_W-1:0]               din,
    input  logic                             din_valid,
    input  logic                             relock,
    input  logic                             prog_valid,
    input  logic [DIGIT_W*PIN_LEN-1:0]       prog_pin,
    output logic                             unlocked,
    output logic                             locked_out,
    output logic [$clog2(MAX_TRIES+1)-1:0]   fail_count,
    output logic [$clog2(PIN_LEN+1)-1:0]     digits_entered
);

    localparam int PIN_W = DIGIT_W * PIN_LEN;
    localparam int FC_W  = $clog2(MAX_TRIES + 1);
    localparam int DE_W  = $clog2(PIN_LEN + 1);
    localparam int TM_W  = $clog2(LOCKOUT_CYCLES + 1);
    // The digit table is padded to a power of two so it can be indexed
    // directly by the full-width digit counter.
    localparam int NSLOT = 1 << DE_W;

    typedef enum logic [1:0] {
        ST_ENTRY    = 2'd0,
        ST_UNLOCKED = 2'd1,
        ST_LOCKOUT  = 2'd2
    } state_t;

    state_t             state_q,    state_d;
    logic [PIN_W-1:0]   pin_q,      pin_d;
    logic [FC_W-1:0]    fail_q,     fail_d;
    logic [DE_W-1:0]    digits_q,   digits_d;
    logic               mismatch_q, mismatch_d;
    logic [TM_W-1:0]    timer_q,    timer_d;

    // Working values for the digit being judged this cycle.
    logic [DE_W-1:0]    pos;
    logic               mm_cur;
    logic               mm_new;

    // Stored PIN split into digits; slot 0 holds the most significant digit.
    logic [DIGIT_W-1:0] pin_slot [NSLOT];

    genvar gi;
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_slot
            if (gi < PIN_LEN) begin : g_used
                assign pin_slot[gi] = pin_q[(PIN_LEN-1-gi)*DIGIT_W +: DIGIT_W];
            end else begin : g_pad
                assign pin_slot[gi] = '0;
            end
        end
    endgenerate

`ifdef SAFE_TIMEOUT_EN
    localparam int ID_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [ID_W-1:0]    idle_q, idle_d;
    logic               expired;

    // Idle counter register for the inter-digit timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    // Timeout is not built; keep the parameter referenced so it stays visible.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    // State register and all controller flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_ENTRY;
            pin_q      <= RESET_PIN;
            fail_q     <= '0;
            digits_q   <= '0;
            mismatch_q <= 1'b0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            pin_q      <= pin_d;
            fail_q     <= fail_d;
            digits_q   <= digits_d;
            mismatch_q <= mismatch_d;
            timer_q    <= timer_d;
        end
    end

    // Next-state logic: entry judging, unlock/program handling, lockout timer.
    always_comb begin
        state_d    = state_q;
        pin_d      = pin_q;
        fail_d     = fail_q;
        digits_d   = digits_q;
        mismatch_d = mismatch_q;
        timer_d    = timer_q;
        pos        = digits_q;
        mm_cur     = mismatch_q;
        mm_new     = mismatch_q;
`ifdef SAFE_TIMEOUT_EN
        idle_d     = '0;
        expired    = 1'b0;
`endif

        case (state_q)
            ST_ENTRY: begin
`ifdef SAFE_TIMEOUT_EN
                // An expired partial entry is dropped; a digit arriving in the
                // same cycle starts a fresh entry at position 0.
                expired = (digits_q != '0) && (idle_q == ID_W'(TIMEOUT_CYCLES));
                if (expired) begin
                    pos        = '0;
                    mm_cur     = 1'b0;
                    digits_d   = '0;
                    mismatch_d = 1'b0;
                end
`endif
                if (din_valid) begin
                    mm_new = mm_cur | (din != pin_slot[pos]);
                    if (pos == DE_W'(PIN_LEN - 1)) begin
                        digits_d   = '0;
                        mismatch_d = 1'b0;
                        if (!mm_new) begin
                            state_d = ST_UNLOCKED;
                            fail_d  = '0;
                        end else if (fail_q == FC_W'(MAX_TRIES - 1)) begin
                            state_d = ST_LOCKOUT;
                            timer_d = TM_W'(LOCKOUT_CYCLES);
                            fail_d  = FC_W'(MAX_TRIES);
                        end else begin
                            fail_d  = fail_q + FC_W'(1);
                        end
                    end else begin
                        digits_d   = pos + DE_W'(1);
                        mismatch_d = mm_new;
                    end
                end
`ifdef SAFE_TIMEOUT_EN
                if (!din_valid && (digits_d != '0)) begin
                    idle_d = idle_q + ID_W'(1);
                end
`endif
            end

            ST_UNLOCKED: begin
                if (prog_valid) begin
                    pin_d = prog_pin;
                end
                if (relock) begin
                    state_d = ST_ENTRY;
                end
            end

            ST_LOCKOUT: begin
                timer_d = timer_q - TM_W'(1);
                if (timer_q <= TM_W'(1)) begin
                    timer_d = '0;
                    state_d = ST_ENTRY;
                    fail_d  = '0;
                end
            end

            default: begin
                state_d = ST_ENTRY;
            end
        endcase
    end

    // Outputs are decoded straight from registers.
    assign unlocked       = (state_q == ST_UNLOCKED);
    assign locked_out     = (state_q == ST_LOCKOUT);
    assign fail_count     = fail_q;
    assign digits_entered = digits_q;

endmodule

// File: tb/tb_safe_lock.sv
// tb_safe_lock: table-driven checks of safe_lock with default parameters,
// plus hand-written sequences for lockout length and partial-entry idling.
module tb_safe_lock;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  din;
    logic        din_valid;
    logic        relock;
    logic        prog_valid;
    logic [15:0] prog_pin;
    logic        unlocked;
    logic        locked_out;
    logic [1:0]  fail_count;
    logic [2:0]  digits_entered;

    safe_lock dut (
        .clk            (clk),
        .reset          (reset),
        .din            (din),
        .din_valid      (din_valid),
        .relock         (relock),
        .prog_valid     (prog_valid),
        .prog_pin       (prog_pin),
        .unlocked       (unlocked),
        .locked_out     (locked_out),
        .fail_count     (fail_count),
        .digits_entered (digits_entered)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        dv;
        logic [3:0]  d;
        logic        rl;
        logic        pv;
        logic [15:0] pp;
        logic        eu;
        logic        elo;
        logic [1:0]  ef;
        logic [2:0]  ed;
    } vec_t;

    vec_t vq[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   vec_no = 0;

    task automatic chk(input string what, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s #%0d: got %0h, expected %0h", what, idx, act, exp);
    endtask

    task automatic drive(input logic rst, input logic dv, input logic [3:0] d,
                         input logic rl, input logic pv, input logic [15:0] pp);
        reset = rst; din_valid = dv; din = d; relock = rl; prog_valid = pv; prog_pin = pp;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic add(input logic rst, input logic dv, input logic [3:0] d,
                       input logic rl, input logic pv, input logic [15:0] pp,
                       input logic eu, input logic elo, input logic [1:0] ef, input logic [2:0] ed);
        vec_t v;
        v.rst = rst; v.dv = dv; v.d = d; v.rl = rl; v.pv = pv; v.pp = pp;
        v.eu = eu; v.elo = elo; v.ef = ef; v.ed = ed;
        vq.push_back(v);
    endtask

    // Four consecutive digits; intermediate rows expect the running count,
    // the final row expects the judged outcome.
    task automatic add_entry(input logic [15:0] pin, input logic [1:0] f0,
                             input logic eu, input logic elo, input logic [1:0] ef);
        logic [3:0] dg;
        for (int i = 0; i < 4; i++) begin
            dg = pin[15-4*i -: 4];
            if (i < 3) add(1'b0, 1'b1, dg, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, f0, 3'(i + 1));
            else       add(1'b0, 1'b1, dg, 1'b0, 1'b0, 16'h0, eu, elo, ef, 3'd0);
        end
    endtask

    task automatic run_table();
        foreach (vq[i]) begin
            drive(vq[i].rst, vq[i].dv, vq[i].d, vq[i].rl, vq[i].pv, vq[i].pp);
            step();
            chk("unlocked",       vec_no, 32'(unlocked),       32'(vq[i].eu));
            chk("locked_out",     vec_no, 32'(locked_out),     32'(vq[i].elo));
            chk("fail_count",     vec_no, 32'(fail_count),     32'(vq[i].ef));
            chk("digits_entered", vec_no, 32'(digits_entered), 32'(vq[i].ed));
            $display("vec %0d: rst=%0b dv=%0b d=%h rl=%0b pv=%0b -> u=%0b lo=%0b f=%0d de=%0d",
                     vec_no, vq[i].rst, vq[i].dv, vq[i].d, vq[i].rl, vq[i].pv,
                     unlocked, locked_out, fail_count, digits_entered);
            vec_no++;
        end
        vq.delete();
        drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic enter_digit(input logic [3:0] d);
        drive(1'b0, 1'b1, d, 1'b0, 1'b0, 16'h0);
        step();
        drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 16'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int         cnt;
        logic       seen_unlock;
        logic [15:0] cp;

        drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 16'h0);

        // Phase A: reset, correct PIN, wrong PIN, drive into lockout.
        add(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 2'd0, 3'd0);
        add_entry(16'hC0DE, 2'd0, 1'b1, 1'b0, 2'd0);
        add(1'b0, 1'b1, 4'h5, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 2'd0, 3'd0);
        add(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 2'd0, 3'd0);
        add_entry(16'hC1DE, 2'd0, 1'b0, 1'b0, 2'd1);
        add(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 2'd1, 3'd0);
        add_entry(16'h0000, 2'd1, 1'b0, 1'b0, 2'd2);
        add_entry(16'h1111, 2'd2, 1'b0, 1'b1, 2'd3);
        run_table();

        // Lockout length, with the correct PIN presented throughout.
        cnt = 1;
        seen_unlock = 1'b0;
        cp = 16'hC0DE;
        for (int i = 0; i < 40; i++) begin
            drive(1'b0, 1'b1, cp[15-4*(i%4) -: 4], 1'b0, 1'b0, 16'h0);
            step();
            if (unlocked) seen_unlock = 1'b1;
            if (!locked_out) break;
            cnt++;
        end
        drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 16'h0);
        chk("lockout_len",       0, 32'(cnt),            32'd16);
        chk("lockout_unlock",    0, 32'(seen_unlock),    32'd0);
        chk("post_lockout_fail", 0, 32'(fail_count),     32'd0);
        chk("post_lockout_de",   0, 32'(digits_entered), 32'd0);
        $display("lockout: locked_out high for %0d cycles, fail_count=%0d", cnt, fail_count);

        // Phase B: unlock, reprogram, ignored programming, resets mid-operation.
        add_entry(16'hC0DE, 2'd0, 1'b1, 1'b0, 2'd0);
        add(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 2'd0, 3'd0);
        add_entry(16'hC0DE, 2'd0, 1'b0, 1'b0, 2'd1);
        add_entry(16'h1234, 2'd1, 1'b1, 1'b0, 2'd0);
        add(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 2'd0, 3'd0);
        add(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 16'h5678, 1'b0, 1'b0, 2'd0, 3'd0);
        add_entry(16'h5678, 2'd0, 1'b0, 1'b0, 2'd1);
        add_entry(16'h1234, 2'd1, 1'b1, 1'b0, 2'd0);
        add(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 2'd0, 3'd0);
        add(1'b0, 1'b1, 4'h1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 2'd0, 3'd1);
        add(1'b0, 1'b1, 4'h2, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 2'd0, 3'd2);
        add(1'b1, 1'b1, 4'h3, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 2'd0, 3'd0);
        add_entry(16'hC0DE, 2'd0, 1'b1, 1'b0, 2'd0);
        add(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 2'd0, 3'd0);
        add_entry(16'h0000, 2'd0, 1'b0, 1'b0, 2'd1);
        add_entry(16'h0000, 2'd1, 1'b0, 1'b0, 2'd2);
        add_entry(16'h0000, 2'd2, 1'b0, 1'b1, 2'd3);
        add(1'b0, 1'b1, 4'hC, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 2'd3, 3'd0);
        add(1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 16'h9999, 1'b0, 1'b1, 2'd3, 3'd0);
        add(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 2'd3, 3'd0);
        add(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 2'd0, 3'd0);
        add_entry(16'hC0DE, 2'd0, 1'b1, 1'b0, 2'd0);
        add(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 2'd0, 3'd0);
        run_table();

        // Partial entry left idle.
        enter_digit(4'hC);
        enter_digit(4'h0);
        chk("partial_de", 0, 32'(digits_entered), 32'd2);
`ifdef SAFE_TIMEOUT_EN
        repeat (33) step();
        chk("timeout_de",   0, 32'(digits_entered), 32'd0);
        chk("timeout_fail", 0, 32'(fail_count),     32'd0);
        enter_digit(4'hC);
        enter_digit(4'h0);
        enter_digit(4'hD);
        enter_digit(4'hE);
        chk("timeout_unlock", 0, 32'(unlocked), 32'd1);
`else
        repeat (40) step();
        chk("idle_de", 0, 32'(digits_entered), 32'd2);
        enter_digit(4'hD);
        enter_digit(4'hE);
        chk("idle_unlock", 0, 32'(unlocked),   32'd1);
        chk("idle_fail",   0, 32'(fail_count), 32'd0);
`endif
        $display("idle entry: unlocked=%0b fail_count=%0d digits_entered=%0d",
                 unlocked, fail_count, digits_entered);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
